// File: rtl/tff_count_pkg.sv
// ---------------------------------------------------------------------------
// tff_count_pkg
//   Shared types and helpers for the TFF-bank counter controller.
//   - ctrl_state_t : controller FSM states.
//   - modulus_ok() : elaboration-time legality check for the count modulus.
// ---------------------------------------------------------------------------
package tff_count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  // A modulus is legal when it spans at least two states and every state
  // fits in the bank.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (width >= 1) && (width <= 30) &&
           (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage : tff_count_pkg

// File: rtl/tff_bit.sv
// ---------------------------------------------------------------------------
// tff_bit
//   One toggle flip-flop with asynchronous active-low clear.
//   Ports:
//     Clk  in   rising-edge clock
//     ClrN in   asynchronous clear, active-low
//     T    in   toggle enable, sampled on the rising edge
//     Q    out  stored bit
// ---------------------------------------------------------------------------
module tff_bit (
  input  logic Clk,
  input  logic ClrN,
  input  logic T,
  output logic Q
);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values, independent of process ordering.
  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule : tff_bit

// File: rtl/tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// tff_count_ctrl
//   Sequencing controller for a bank of WIDTH toggle flip-flops implementing
//   a modulo-MODULUS up/down counter with parallel load, free-run and
//   one-shot modes. The controller computes the desired next value and
//   drives each cell's toggle input with (current ^ next); the bank is never
//   written directly.
//   Parameters:
//     WIDTH    number of TFF bits
//     MODULUS  count modulus, 2 .. 2**WIDTH
//   Ports:
//     Clk      in   rising-edge clock
//     ClrN     in   asynchronous clear, active-low
//     Start    in   IDLE -> RUN request (level)
//     Stop     in   RUN -> IDLE request (level), suppresses the step
//     OneShot  in   1: stop after one wrap, 0: free-run
//     Up       in   count direction, 1 = up
//     Load     in   parallel load request, any state
//     LoadVal  in   value to load (out-of-range loads 0)
//     Q        out  bank contents
//     TC       out  terminal count (combinational)
//     Busy     out  high in RUN
//     Done     out  one-cycle pulse after a one-shot wrap
// ---------------------------------------------------------------------------
module tff_count_ctrl
  import tff_count_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             ClrN,
  input  logic             Start,
  input  logic             Stop,
  input  logic             OneShot,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Busy,
  output logic             Done
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("tff_count_ctrl: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // One bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  ctrl_state_t      state_q, state_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] toggle;
  logic             at_max, at_zero;

  // -------------------------------------------------------------------------
  // Storage bank
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_bit u_bit (
      .Clk  (Clk),
      .ClrN (ClrN),
      .T    (toggle[i]),
      .Q    (Q[i])
    );
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  assign at_max  = (Q == MAX_VAL);
  assign at_zero = (Q == '0);
  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE);
  // TC reflects the wrap condition even when Load or Stop suppresses the step.
  assign TC      = Busy & (Up ? at_max : at_zero);

  // -------------------------------------------------------------------------
  // Next value and next state
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt     = Q;
    state_d = state_q;

    unique case (state_q)
      IDLE: begin
        if (Start && !Stop) state_d = RUN;
      end
      RUN: begin
        if (Stop) begin
          state_d = IDLE;
        end else begin
          if (Up) nxt = at_max  ? '0      : Q + ONE;
          else    nxt = at_zero ? MAX_VAL : Q - ONE;
          if (OneShot && TC) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Load wins over Stop and counting; it leaves IDLE/RUN in place while
    // DONE still retires to IDLE.
    if (Load) begin
      nxt = ({1'b0, LoadVal} < MOD_EXT) ? LoadVal : '0;
      if (state_q != DONE) state_d = state_q;
    end
  end

  assign toggle = Q ^ nxt;

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule : tff_count_ctrl
